// File: rtl/montacargas_pkg.sv
// Shared types and defaults for the floor controller.
package montacargas_pkg;

    // state     | meaning
    // IDLE      | parked at r_bcd, choosing the next action from pending
    // MOVE_UP   | travelling one floor up, travel timer running
    // MOVE_DOWN | travelling one floor down, travel timer running
    // DOOR_OPEN | door held open for the door time
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam int N_FLOORS_DEF = 5;
    localparam int BCD_W        = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/floor_ctrl_if.sv
// Call/status bundle between the floor controller and its surroundings.
// The estop line exists only when FLOOR_CTRL_ESTOP_EN is defined.
interface floor_ctrl_if
    import montacargas_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF
) ();
    logic [N_FLOORS-1:0] call;
    logic [BCD_W-1:0]    bcd;
    logic                moving_up;
    logic                moving_down;
    logic                door_open;
    logic [N_FLOORS-1:0] pending;
`ifdef FLOOR_CTRL_ESTOP_EN
    logic                estop;

    modport master (
        output call, estop,
        input  bcd, moving_up, moving_down, door_open, pending
    );
    modport slave (
        input  call, estop,
        output bcd, moving_up, moving_down, door_open, pending
    );
`else
    modport master (
        output call,
        input  bcd, moving_up, moving_down, door_open, pending
    );
    modport slave (
        input  call,
        output bcd, moving_up, moving_down, door_open, pending
    );
`endif
endinterface

// File: rtl/cycle_timer.sv
// Shared down-counter for travel and door intervals; done at terminal count 0.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         hold,
    output logic         done
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/floor_ctrl.sv
// Single-car floor controller: latches calls, travels floor by floor, opens the door.
// Optional emergency stop freeze is compiled in with FLOOR_CTRL_ESTOP_EN.
module floor_ctrl
    import montacargas_pkg::*;
#(
    parameter int N_FLOORS      = N_FLOORS_DEF,
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    floor_ctrl_if.slave bus
);
    localparam int               CNT_W     = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LD   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [BCD_W-1:0] TOP_FLOOR = BCD_W'(N_FLOORS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_bcd_next;
    logic [N_FLOORS-1:0] r_pending;
    logic [N_FLOORS-1:0] w_pending_next;
    logic [N_FLOORS-1:0] w_clear;
    logic                r_moving_up;
    logic                r_moving_down;
    logic                r_door_open;
    logic                w_moving_up_next;
    logic                w_moving_down_next;
    logic                w_door_open_next;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_val;
    logic                w_done;
    logic                w_hold;
    logic                w_pend_cur;
    logic                w_pend_up;
    logic                w_pend_dn;
    logic                w_above_cur;
    logic                w_below_cur;
    logic                w_above_up;
    logic                w_below_dn;

`ifdef FLOOR_CTRL_ESTOP_EN
    assign w_hold = bus.estop;
`else
    assign w_hold = 1'b0;
`endif

    cycle_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .value (w_load_val),
        .hold  (w_hold),
        .done  (w_done)
    );

    // Request views relative to the current floor and to the floor about to be reached.
    always_comb begin
        w_pend_cur  = 1'b0;
        w_pend_up   = 1'b0;
        w_pend_dn   = 1'b0;
        w_above_cur = 1'b0;
        w_below_cur = 1'b0;
        w_above_up  = 1'b0;
        w_below_dn  = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i == int'(r_bcd))     w_pend_cur  = w_pend_cur  | r_pending[i];
            if (i == int'(r_bcd) + 1) w_pend_up   = w_pend_up   | r_pending[i];
            if (i == int'(r_bcd) - 1) w_pend_dn   = w_pend_dn   | r_pending[i];
            if (i >  int'(r_bcd))     w_above_cur = w_above_cur | r_pending[i];
            if (i <  int'(r_bcd))     w_below_cur = w_below_cur | r_pending[i];
            if (i >  int'(r_bcd) + 1) w_above_up  = w_above_up  | r_pending[i];
            if (i <  int'(r_bcd) - 1) w_below_dn  = w_below_dn  | r_pending[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bcd         <= '0;
            r_pending     <= '0;
            r_moving_up   <= 1'b0;
            r_moving_down <= 1'b0;
            r_door_open   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bcd         <= w_bcd_next;
            r_pending     <= w_pending_next;
            r_moving_up   <= w_moving_up_next;
            r_moving_down <= w_moving_down_next;
            r_door_open   <= w_door_open_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bcd_next   = r_bcd;
        w_load       = 1'b0;
        w_load_val   = TRAVEL_LD;
        if (!w_hold) begin
            case (r_state)
                IDLE: begin
                    if (w_pend_cur) begin
                        w_state_next = DOOR_OPEN;
                        w_load       = 1'b1;
                        w_load_val   = DOOR_LD;
                    end else if (w_above_cur) begin
                        w_state_next = MOVE_UP;
                        w_load       = 1'b1;
                    end else if (w_below_cur) begin
                        w_state_next = MOVE_DOWN;
                        w_load       = 1'b1;
                    end
                end
                MOVE_UP: begin
                    if (w_done) begin
                        if (r_bcd >= TOP_FLOOR) begin
                            w_state_next = IDLE;
                        end else begin
                            w_bcd_next = r_bcd + BCD_W'(1);
                            if (w_pend_up) begin
                                w_state_next = DOOR_OPEN;
                                w_load       = 1'b1;
                                w_load_val   = DOOR_LD;
                            end else if (w_above_up) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_next = IDLE;
                            end
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (w_done) begin
                        if (r_bcd == '0) begin
                            w_state_next = IDLE;
                        end else begin
                            w_bcd_next = r_bcd - BCD_W'(1);
                            if (w_pend_dn) begin
                                w_state_next = DOOR_OPEN;
                                w_load       = 1'b1;
                                w_load_val   = DOOR_LD;
                            end else if (w_below_dn) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_next = IDLE;
                            end
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (w_done) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The served floor's bit is masked on the entry edge and for the whole door interval.
    always_comb begin
        w_clear = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (w_state_next == DOOR_OPEN && i == int'(w_bcd_next)) w_clear[i] = 1'b1;
        end
        w_pending_next     = (r_pending | bus.call) & ~w_clear;
        w_moving_up_next   = (w_state_next == MOVE_UP) && !w_hold;
        w_moving_down_next = (w_state_next == MOVE_DOWN) && !w_hold;
        w_door_open_next   = (w_state_next == DOOR_OPEN);
    end

    assign bus.bcd         = r_bcd;
    assign bus.pending     = r_pending;
    assign bus.moving_up   = r_moving_up;
    assign bus.moving_down = r_moving_down;
    assign bus.door_open   = r_door_open;

endmodule

// File: tb/tb_floor_ctrl.sv
// Directed bench for floor_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=3, five floors.
module tb_floor_ctrl;
    localparam int NF = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    floor_ctrl_if #(.N_FLOORS(NF)) bus ();

    floor_ctrl #(
        .N_FLOORS      (NF),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          rst_n;
        logic [NF-1:0] call;
        logic [3:0]    bcd;
        logic          up;
        logic          dn;
        logic          door;
        logic [NF-1:0] pend;
    } vec_t;

    vec_t tv [24];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic prev_door = 1'b0;
    int   door_log [$];
    logic ok;

    function automatic vec_t mk(input logic r, input logic [NF-1:0] c, input logic [3:0] b,
                                input logic u, input logic d, input logic o, input logic [NF-1:0] p);
        vec_t v;
        v.rst_n = r; v.call = c; v.bcd = b; v.up = u; v.dn = d; v.door = o; v.pend = p;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.door_open && !prev_door) door_log.push_back(int'(bus.bcd));
        prev_door = bus.door_open;
    endtask

    task automatic pulse(input logic [NF-1:0] c);
        bus.call = c;
        tick();
        bus.call = '0;
    endtask

    task automatic run_idle(input int budget, output logic done);
        int n;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            if (!bus.moving_up && !bus.moving_down && !bus.door_open && bus.pending == '0)
                done = 1'b1;
        end
    endtask

    task automatic wait_bcd(input int target, input int budget, output logic hit);
        int n;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            tick();
            n++;
            if (int'(bus.bcd) == target) hit = 1'b1;
        end
    endtask

    task automatic chk_all(input string tag, input int b, input int u, input int d, input int o, input int p);
        chk({tag, ".bcd"},  int'(bus.bcd), b);
        chk({tag, ".up"},   int'(bus.moving_up), u);
        chk({tag, ".dn"},   int'(bus.moving_down), d);
        chk({tag, ".door"}, int'(bus.door_open), o);
        chk({tag, ".pend"}, int'(bus.pending), p);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.call = '0;
`ifdef FLOOR_CTRL_ESTOP_EN
        bus.estop = 1'b0;
`endif
        // reset, call at the current floor, then a three-floor climb with door at 3
        tv[0]  = mk(0, 5'b00000, 0, 0, 0, 0, 5'b00000);
        tv[1]  = mk(0, 5'b00000, 0, 0, 0, 0, 5'b00000);
        tv[2]  = mk(1, 5'b00001, 0, 0, 0, 0, 5'b00001);
        tv[3]  = mk(1, 5'b00000, 0, 0, 0, 1, 5'b00000);
        tv[4]  = mk(1, 5'b00000, 0, 0, 0, 1, 5'b00000);
        tv[5]  = mk(1, 5'b00000, 0, 0, 0, 1, 5'b00000);
        tv[6]  = mk(1, 5'b00000, 0, 0, 0, 0, 5'b00000);
        tv[7]  = mk(1, 5'b01000, 0, 0, 0, 0, 5'b01000);
        tv[8]  = mk(1, 5'b00000, 0, 1, 0, 0, 5'b01000);
        tv[9]  = mk(1, 5'b00000, 0, 1, 0, 0, 5'b01000);
        tv[10] = mk(1, 5'b00000, 0, 1, 0, 0, 5'b01000);
        tv[11] = mk(1, 5'b00000, 0, 1, 0, 0, 5'b01000);
        tv[12] = mk(1, 5'b00000, 1, 1, 0, 0, 5'b01000);
        tv[13] = mk(1, 5'b00000, 1, 1, 0, 0, 5'b01000);
        tv[14] = mk(1, 5'b00000, 1, 1, 0, 0, 5'b01000);
        tv[15] = mk(1, 5'b00000, 1, 1, 0, 0, 5'b01000);
        tv[16] = mk(1, 5'b00000, 2, 1, 0, 0, 5'b01000);
        tv[17] = mk(1, 5'b00000, 2, 1, 0, 0, 5'b01000);
        tv[18] = mk(1, 5'b00000, 2, 1, 0, 0, 5'b01000);
        tv[19] = mk(1, 5'b00000, 2, 1, 0, 0, 5'b01000);
        tv[20] = mk(1, 5'b00000, 3, 0, 0, 1, 5'b00000);
        tv[21] = mk(1, 5'b00000, 3, 0, 0, 1, 5'b00000);
        tv[22] = mk(1, 5'b00000, 3, 0, 0, 1, 5'b00000);
        tv[23] = mk(1, 5'b00000, 3, 0, 0, 0, 5'b00000);

        for (int k = 0; k < 24; k++) begin
            rst_n    = tv[k].rst_n;
            bus.call = tv[k].call;
            tick();
            chk_all($sformatf("vec%0d", k), int'(tv[k].bcd), int'(tv[k].up), int'(tv[k].dn),
                    int'(tv[k].door), int'(tv[k].pend));
        end
        bus.call = '0;

        // park at floor 2, then simultaneous calls above and below
        pulse(5'b00100);
        run_idle(200, ok);
        chk("pre_split.done", int'(ok), 1);
        chk("pre_split.bcd", int'(bus.bcd), 2);
        door_log.delete();
        pulse(5'b10001);
        chk("split.pend", int'(bus.pending), 5'b10001);
        tick();
        chk("split.up_first", int'(bus.moving_up), 1);
        chk("split.dn_first", int'(bus.moving_down), 0);
        run_idle(200, ok);
        chk("split.done", int'(ok), 1);
        chk("split.ndoors", door_log.size(), 2);
        chk("split.door0", door_log.size() > 0 ? door_log[0] : -1, 4);
        chk("split.door1", door_log.size() > 1 ? door_log[1] : -1, 0);
        chk("split.bcd", int'(bus.bcd), 0);
        chk("split.pend_end", int'(bus.pending), 0);

        // call added for floor 2 while passing floor 1 on the way to 4
        door_log.delete();
        pulse(5'b10000);
        wait_bcd(1, 20, ok);
        chk("midcall.reach1", int'(ok), 1);
        pulse(5'b00100);
        chk("midcall.pend", int'(bus.pending), 5'b10100);
        run_idle(200, ok);
        chk("midcall.done", int'(ok), 1);
        chk("midcall.ndoors", door_log.size(), 2);
        chk("midcall.door0", door_log.size() > 0 ? door_log[0] : -1, 2);
        chk("midcall.door1", door_log.size() > 1 ? door_log[1] : -1, 4);
        chk("midcall.bcd", int'(bus.bcd), 4);

`ifdef FLOOR_CTRL_ESTOP_EN
        // freeze mid-travel from 4 toward 3, a call captured while frozen
        pulse(5'b01000);
        tick();
        chk("estop.dn_start", int'(bus.moving_down), 1);
        tick();
        tick();
        bus.estop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.call = (k == 4) ? 5'b00001 : 5'b00000;
            tick();
            chk($sformatf("estop%0d.bcd", k), int'(bus.bcd), 4);
            chk($sformatf("estop%0d.dn", k), int'(bus.moving_down), 0);
        end
        bus.call = '0;
        chk("estop.pend", int'(bus.pending), 5'b01001);
        bus.estop = 1'b0;
        tick();
        chk_all("estop_rel1", 4, 0, 1, 0, 5'b01001);
        tick();
        chk_all("estop_rel2", 3, 0, 0, 1, 5'b00001);
        run_idle(200, ok);
        chk("estop.done", int'(ok), 1);
        chk("estop.bcd_end", int'(bus.bcd), 0);
`endif

        // reset in the middle of a move drops everything back to floor 0
        pulse((bus.bcd == 4'd0) ? 5'b10000 : 5'b00001);
        repeat (5) tick();
        chk("abort.moving", int'(bus.moving_up | bus.moving_down), 1);
        rst_n = 1'b0;
        tick();
        chk_all("abort.rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all("abort.after", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/floor_ctrl.md
FLOOR_CTRL -- requirements
Module: floor_ctrl

Interface
REQ-001 SHALL have parameter N_FLOORS, default 5, number of served floors (0..N_FLOORS-1, max 10).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 50_000_000, clock cycles per one-floor move.
REQ-003 SHALL have parameter DOOR_CYCLES, default 100_000_000, clock cycles the door stays open.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port call  input  N_FLOORS  call buttons; call[i] high for one or more cycles requests floor i.
REQ-007 SHALL have port bcd  output  4  current floor, binary 0..N_FLOORS-1; feeds the 7-segment display decoder.
REQ-008 SHALL have ports moving_up, moving_down, door_open  output  1 each  status flags.
REQ-009 SHALL have port pending  output  N_FLOORS  registered outstanding requests.

Function
REQ-010 SHALL have FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; exactly one active.
REQ-011 SHALL set pending[i] at the edge where call[i] is sampled high; a bit that is already set stays set.
REQ-012 SHALL clear pending[bcd] at the edge entering DOOR_OPEN; a call[bcd] sampled while in DOOR_OPEN is ignored.
REQ-013 IDLE: pending[bcd] set -> DOOR_OPEN. Else any pending above bcd -> MOVE_UP. Else any pending below -> MOVE_DOWN. Else stay.
REQ-014 SHALL give MOVE_UP priority over MOVE_DOWN when IDLE and requests exist both above and below.
REQ-015 On entering MOVE_UP/MOVE_DOWN, SHALL load the travel counter with TRAVEL_CYCLES-1.
REQ-016 On expiry after TRAVEL_CYCLES cycles, SHALL step bcd by +1 (up) or -1 (down).
REQ-017 At the same expiry edge: new floor pending -> DOOR_OPEN. Else requests further in the same direction -> stay and reload. Else IDLE.
REQ-018 SHALL hold DOOR_OPEN exactly DOOR_CYCLES cycles, then go to IDLE.
REQ-019 SHALL saturate bcd: never above N_FLOORS-1, never below 0; MOVE_UP at top or MOVE_DOWN at bottom -> IDLE without stepping.
REQ-020 SHALL drive moving_up=1 only in MOVE_UP, moving_down=1 only in MOVE_DOWN, and door_open=1 only in DOOR_OPEN; all outputs registered.
REQ-021 SHALL use request bits added during a move in the next direction decision (REQ-017).

Reset
REQ-022 SHALL, while rst_n=0 at an edge, set state=IDLE, bcd=0, pending=0, all flags 0, counters 0.
REQ-023 SHALL abort any move or door cycle on reset; bcd returns to 0 and no partial step is kept.

Configuration
REQ-024 SHALL, with macro FLOOR_CTRL_ESTOP_EN defined, add input estop (1 bit, active-high).
REQ-025 With FLOOR_CTRL_ESTOP_EN, estop=1: freeze state, counters and bcd; force moving_up/moving_down to 0; door_open holds its value; pending keeps capturing calls.
REQ-026 With FLOOR_CTRL_ESTOP_EN, release of estop SHALL resume the counter from its frozen value.
REQ-027 Without FLOOR_CTRL_ESTOP_EN, there SHALL be no estop port or logic.

Structure
REQ-028 SHALL place the state enum typedef and the default N_FLOORS constant in shared package montacargas_pkg.
REQ-029 SHALL implement the travel and door countdown in one sub-module, cycle_timer, with inputs load, value, hold and output done.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-030 Reset: rst_n=0 for 2 cycles -> bcd=0, pending=0, all flags 0.
REQ-031 call[0] pulse at floor 0 -> door_open=1 from the second edge after the pulse for 3 cycles, then IDLE; pending[0] cleared.
REQ-032 call[3] pulse from floor 0 -> moving_up; bcd steps 1, 2, 3 every 4 cycles; door_open at floor 3; moving_up=0.
REQ-033 At floor 2 IDLE, call[4] and call[0] in the same cycle -> up to 4, door, then down to 0, door; pending ends 0.
REQ-034 While moving up from 0 to 4, call[2] while bcd=1 -> stops at 2 with door before continuing to 4.
REQ-035 With FLOOR_CTRL_ESTOP_EN: estop for 10 cycles mid-travel -> bcd frozen, moving flags 0; after release the step completes after the remaining cycles.
